// File: rtl/controlunit_pipe_if.sv
// D-to-E handshake bundle for controlunit_pipe.
// MulDivE exists only when CTRL_MULDIV_EN is defined.
interface controlunit_pipe_if #(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 8
);
    logic [XLEN-1:0]      InstrD;
    logic                 ValidD;
    logic                 ReadyD;
    logic                 ReadyE;
    logic                 StallE;
    logic                 FlushE;
    logic                 ValidE;
    logic                 RegWriteE;
    logic [1:0]           ResultSrcE;
    logic                 MemWriteE;
    logic                 JumpE;
    logic                 BranchE;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic                 ALUSrcE;
    logic [2:0]           ImmSrcE;
    logic                 IllegalE;
    logic [CNT_W-1:0]     IllegalCnt;
`ifdef CTRL_MULDIV_EN
    logic                 MulDivE;
`endif

    modport slave (
        input  InstrD, ValidD, ReadyE, StallE, FlushE,
        output ReadyD, ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE,
               BranchE, ALUControlE, ALUSrcE, ImmSrcE, IllegalE, IllegalCnt
`ifdef CTRL_MULDIV_EN
        , output MulDivE
`endif
    );

    modport master (
        output InstrD, ValidD, ReadyE, StallE, FlushE,
        input  ReadyD, ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE,
               BranchE, ALUControlE, ALUSrcE, ImmSrcE, IllegalE, IllegalCnt
`ifdef CTRL_MULDIV_EN
        , input MulDivE
`endif
    );
endinterface

// File: rtl/controlunit_pipe.sv
// RV32I decode stage with registered E-stage control word, stall/flush and
// saturating illegal-instruction counter. Optional RV32M decode: CTRL_MULDIV_EN.
module controlunit_pipe #(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    controlunit_pipe_if.slave     bus
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("controlunit_pipe: XLEN must be 32");
    end
    if (ALUCTRL_W < 4) begin : g_bad_aluw
        $error("controlunit_pipe: ALUCTRL_W must be >= 4");
    end
`ifdef CTRL_MULDIV_EN
    if (ALUCTRL_W < 5) begin : g_bad_aluw_md
        $error("controlunit_pipe: ALUCTRL_W must be >= 5 with RV32M");
    end
`endif

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic                 alu_src;
        logic [2:0]           imm_src;
        logic                 illegal;
`ifdef CTRL_MULDIV_EN
        logic                 muldiv;
`endif
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = bus.InstrD[6:0];
    assign funct3 = bus.InstrD[14:12];
    assign funct7 = bus.InstrD[31:25];
    assign unused_instr_bits = ^{bus.InstrD[24:15], bus.InstrD[11:7]};

    ctrl_t   ctrl_d, ctrl_q;
    alu_op_e alu_op;
    logic    legal;
    logic    use_raw_alu;

    // funct3 -> ALU op for the base R / I-ALU group (shifts and SUB refined below)
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

    always_comb begin
        ctrl_d      = '0;
        alu_op      = ALU_ADD;
        legal       = 1'b0;
        use_raw_alu = 1'b0;
        if (bus.InstrD[1:0] == 2'b11) begin
            case (opcode)
                OP_R: begin
                    ctrl_d.reg_write = 1'b1;
                    alu_op           = base_alu(funct3);
                    if (funct7 == 7'b0000000) begin
                        legal = 1'b1;
                    end else if (funct7 == 7'b0100000) begin
                        legal  = (funct3 == 3'b000) || (funct3 == 3'b101);
                        alu_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
`ifdef CTRL_MULDIV_EN
                    end else if (funct7 == 7'b0000001) begin
                        legal           = 1'b1;
                        use_raw_alu     = 1'b1;
                        ctrl_d.muldiv   = 1'b1;
                        ctrl_d.alu_ctrl = ALUCTRL_W'({1'b1, funct3});
`endif
                    end
                end
                OP_IALU: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    alu_op           = base_alu(funct3);
                    if (funct3 == 3'b001) begin
                        legal = (funct7 == 7'b0000000);
                    end else if (funct3 == 3'b101) begin
                        legal  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    end else begin
                        legal = 1'b1;
                    end
                end
                OP_LOAD: begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.result_src = 2'b01;
                    ctrl_d.alu_src    = 1'b1;
                    legal = (funct3 <= 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b101);
                end
                OP_STORE: begin
                    ctrl_d.mem_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.imm_src   = 3'b001;
                    legal            = (funct3 <= 3'b010);
                end
                OP_BRANCH: begin
                    ctrl_d.branch  = 1'b1;
                    ctrl_d.imm_src = 3'b010;
                    alu_op         = ALU_SUB;
                    legal          = (funct3 != 3'b010) && (funct3 != 3'b011);
                end
                OP_JAL: begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.jump       = 1'b1;
                    ctrl_d.result_src = 2'b10;
                    ctrl_d.imm_src    = 3'b011;
                    legal             = 1'b1;
                end
                OP_JALR: begin
                    ctrl_d.reg_write  = 1'b1;
                    ctrl_d.jump       = 1'b1;
                    ctrl_d.result_src = 2'b10;
                    ctrl_d.alu_src    = 1'b1;
                    legal             = (funct3 == 3'b000);
                end
                OP_LUI: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.imm_src   = 3'b100;
                    alu_op           = ALU_PASSB;
                    legal            = 1'b1;
                end
                OP_AUIPC: begin
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.imm_src   = 3'b100;
                    legal            = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end
        if (!use_raw_alu) begin
            ctrl_d.alu_ctrl = ALUCTRL_W'(alu_op);
        end
        // Illegal words carry no side effects into E, only the flag.
        if (!legal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
        end
    end

    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             can_accept;
    logic             accept;

    assign can_accept = (!valid_q || bus.ReadyE) && !bus.StallE;
    assign accept     = bus.ValidD && can_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else if (bus.FlushE) begin
            valid_q          <= 1'b0;
            ctrl_q.illegal   <= 1'b0;
            ctrl_q.reg_write <= 1'b0;
            ctrl_q.mem_write <= 1'b0;
            ctrl_q.jump      <= 1'b0;
            ctrl_q.branch    <= 1'b0;
`ifdef CTRL_MULDIV_EN
            ctrl_q.muldiv    <= 1'b0;
`endif
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            if (ctrl_d.illegal && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (valid_q && bus.ReadyE && !bus.StallE) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ReadyD      = can_accept;
    assign bus.ValidE      = valid_q;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.ALUControlE = ctrl_q.alu_ctrl;
    assign bus.ALUSrcE     = ctrl_q.alu_src;
    assign bus.ImmSrcE     = ctrl_q.imm_src;
    assign bus.IllegalE    = ctrl_q.illegal;
    assign bus.IllegalCnt  = cnt_q;
`ifdef CTRL_MULDIV_EN
    assign bus.MulDivE     = ctrl_q.muldiv;
`endif
endmodule

// File: tb/tb_controlunit_pipe.sv
// Directed self-checking bench for controlunit_pipe (both CTRL_MULDIV_EN builds).
module tb_controlunit_pipe;
`ifdef CTRL_MULDIV_EN
    localparam int ACW = 5;
`else
    localparam int ACW = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    controlunit_pipe_if #(.XLEN(32), .ALUCTRL_W(ACW), .CNT_W(8)) bus ();

    controlunit_pipe #(.XLEN(32), .ALUCTRL_W(ACW), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] enables();
        return {bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE};
    endfunction

    initial begin
        rst        = 1'b1;
        bus.ValidD = 1'b0;
        bus.InstrD = 32'h0;
        bus.ReadyE = 1'b1;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        tick();
        tick();
        chk("rst_valid", bus.ValidE, 0);
        chk("rst_en", enables(), 0);
        chk("rst_cnt", bus.IllegalCnt, 0);
        chk("rst_illegal", bus.IllegalE, 0);
        rst = 1'b0;
        #1;
        chk("rst_readyd", bus.ReadyD, 1);

        // ADD x1,x2,x3
        bus.ValidD = 1'b1;
        bus.InstrD = 32'h003100B3;
        tick();
        chk("add_valid", bus.ValidE, 1);
        chk("add_regw", bus.RegWriteE, 1);
        chk("add_alusrc", bus.ALUSrcE, 0);
        chk("add_alu", bus.ALUControlE, 0);
        chk("add_res", bus.ResultSrcE, 0);
        chk("add_memw", bus.MemWriteE, 0);
        chk("add_ill", bus.IllegalE, 0);

        bus.InstrD = 32'h000023B7;   // LUI
        tick();
        chk("lui_regw", bus.RegWriteE, 1);
        chk("lui_imm", bus.ImmSrcE, 3'b100);
        chk("lui_alusrc", bus.ALUSrcE, 1);
        chk("lui_alu", bus.ALUControlE, 4'b1010);

        bus.InstrD = 32'h007E2023;   // SW
        tick();
        chk("sw_valid", bus.ValidE, 1);
        chk("sw_memw", bus.MemWriteE, 1);
        chk("sw_regw", bus.RegWriteE, 0);
        chk("sw_imm", bus.ImmSrcE, 3'b001);
        chk("sw_alusrc", bus.ALUSrcE, 1);

        // Backpressure: SW held while ADDI waits
        bus.ReadyE = 1'b0;
        bus.InstrD = 32'h00000013;
        #1;
        chk("bp_readyd", bus.ReadyD, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", bus.ValidE, 1);
            chk("bp_memw", bus.MemWriteE, 1);
            chk("bp_imm", bus.ImmSrcE, 3'b001);
            chk("bp_readyd", bus.ReadyD, 0);
        end
        bus.ReadyE = 1'b1;
        #1;
        chk("bp_release", bus.ReadyD, 1);
        tick();
        chk("addi_regw", bus.RegWriteE, 1);
        chk("addi_memw", bus.MemWriteE, 0);
        chk("addi_alusrc", bus.ALUSrcE, 1);
        chk("addi_imm", bus.ImmSrcE, 3'b000);
        chk("addi_alu", bus.ALUControlE, 0);

        bus.InstrD = 32'h00208463;   // BEQ
        tick();
        chk("beq_branch", bus.BranchE, 1);
        chk("beq_regw", bus.RegWriteE, 0);
        chk("beq_alu", bus.ALUControlE, 4'b0001);
        chk("beq_imm", bus.ImmSrcE, 3'b010);

        bus.InstrD = 32'h0080006F;   // JAL
        tick();
        chk("jal_jump", bus.JumpE, 1);
        chk("jal_res", bus.ResultSrcE, 2'b10);
        chk("jal_regw", bus.RegWriteE, 1);
        chk("jal_imm", bus.ImmSrcE, 3'b011);

        // Flush beats a same-cycle accept
        bus.InstrD = 32'h00000013;
        bus.FlushE = 1'b1;
        tick();
        chk("fl_valid", bus.ValidE, 0);
        chk("fl_en", enables(), 0);
        chk("fl_ill", bus.IllegalE, 0);
        bus.InstrD = 32'hFFFFFFFF;
        bus.StallE = 1'b1;
        tick();
        chk("fl_ill_valid", bus.ValidE, 0);
        chk("fl_ill_flag", bus.IllegalE, 0);
        chk("fl_ill_cnt", bus.IllegalCnt, 0);
        bus.FlushE = 1'b0;

        // Stall blocks accept and counting
        #1;
        chk("st_readyd", bus.ReadyD, 0);
        tick();
        chk("st_valid", bus.ValidE, 0);
        chk("st_cnt", bus.IllegalCnt, 0);
        bus.StallE = 1'b0;

        for (int i = 0; i < 300; i++) begin
            tick();
            chk("ill_flag", bus.IllegalE, 1);
            chk("ill_valid", bus.ValidE, 1);
            chk("ill_en", enables(), 0);
            chk("ill_cnt", bus.IllegalCnt, (i + 1 > 255) ? 255 : i + 1);
        end

        bus.InstrD = 32'h0000B003;   // load funct3 011
        tick();
        chk("ld011_ill", bus.IllegalE, 1);
        chk("ld011_en", enables(), 0);
        chk("sat_cnt", bus.IllegalCnt, 255);
        bus.InstrD = 32'h00000010;   // low bits != 11
        tick();
        chk("lowbits_ill", bus.IllegalE, 1);
        bus.InstrD = 32'h403100B3;   // SUB
        tick();
        chk("sub_ill", bus.IllegalE, 0);
        chk("sub_alu", bus.ALUControlE, 4'b0001);
        chk("sub_regw", bus.RegWriteE, 1);

        bus.InstrD = 32'h023100B3;   // MUL
        tick();
`ifdef CTRL_MULDIV_EN
        chk("mul_muldiv", bus.MulDivE, 1);
        chk("mul_alu", bus.ALUControlE, 5'b01000);
        chk("mul_ill", bus.IllegalE, 0);
`else
        chk("mul_ill", bus.IllegalE, 1);
        chk("mul_en", enables(), 0);
`endif
        chk("mul_cnt", bus.IllegalCnt, 255);

        // Reset mid-stream drops the in-flight word
        bus.InstrD = 32'h00000013;
        rst = 1'b1;
        tick();
        chk("mrst_valid", bus.ValidE, 0);
        chk("mrst_cnt", bus.IllegalCnt, 0);
        chk("mrst_en", enables(), 0);
        rst = 1'b0;
        bus.ValidD = 1'b0;
        tick();
        chk("idle_valid", bus.ValidE, 0);
        chk("idle_readyd", bus.ReadyD, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
